pio_rmw_arbiter: RTL and testbench



---
 rtl/pio_rmw_arbiter.sv | 113 +++++++++++
 tb/tb_pio_rmw_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pio_rmw_arbiter.sv
// pio_rmw_arbiter: round-robin arbiter issuing plain writes and atomic
// set/clear/toggle read-modify-write sequences to PIO register 0.
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   req_valid/op/data per-requester request, op (2 bits each), value or mask
//   req_ack           one-hot completion pulse, asserted in the WR cycle
//   pio_*             Avalon-MM PIO slave signals (address fixed at 0)
//   busy              high whenever the FSM is not IDLE
module pio_rmw_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [2*NUM_REQ-1:0]      req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [1:0]                pio_address,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [DATA_W-1:0]         pio_writedata,
    input  logic [DATA_W-1:0]         pio_readdata,
    output logic                      busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t              r_state, w_next;
    logic [IW-1:0]       r_rr_ptr, r_win, w_win, w_ack_idx;
    logic [1:0]          r_op, w_op;
    logic [DATA_W-1:0]   r_data, w_sel_data, w_rmw, w_wdata;
    logic [NUM_REQ-1:0]  w_ack;
    logic                w_found;
    int                  w_idx;

    // First asserted request at or above rr_ptr, searching upward with wrap.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_found && req_valid[w_idx[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IW-1:0];
            end
        end
    end

    assign w_op       = req_op[2*w_win +: 2];
    assign w_sel_data = req_data[DATA_W*w_win +: DATA_W];

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_found ? ((w_op == 2'b00) ? WR : RD) : IDLE;
            RD:      w_next = WR;
            default: w_next = IDLE;
        endcase
    end

    // Output logic: values the registered outputs take in the next cycle.
    // The RD-cycle read value is folded straight into the registered write
    // data, so the captured read result lives in pio_writedata.
    always_comb begin
        w_rmw = (r_op == 2'b01) ? (pio_readdata | r_data) :
                (r_op == 2'b10) ? (pio_readdata & ~r_data) :
                                  (pio_readdata ^ r_data);
        w_wdata = (r_state == IDLE && w_next == WR) ? w_sel_data :
                  (r_state == RD)                  ? w_rmw : '0;
        w_ack_idx = (r_state == IDLE) ? w_win : r_win;
        w_ack = (w_next == WR) ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_ack_idx) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rr_ptr       <= '0;
            r_win          <= '0;
            r_op           <= '0;
            r_data         <= '0;
            req_ack        <= '0;
            pio_address    <= '0;
            pio_chipselect <= 1'b0;
            pio_write_n    <= 1'b1;
            pio_writedata  <= '0;
            busy           <= 1'b0;
        end else begin
            if (r_state == IDLE && w_found) begin
                r_win  <= w_win;
                r_op   <= w_op;
                r_data <= w_sel_data;
            end
            if (r_state == WR)
                r_rr_ptr <= (r_win == IW'(NUM_REQ-1)) ? '0 : r_win + 1'b1;
            req_ack        <= w_ack;
            pio_address    <= '0;
            pio_chipselect <= (w_next != IDLE);
            pio_write_n    <= (w_next != WR);
            pio_writedata  <= w_wdata;
            busy           <= (w_next != IDLE);
        end
    end
endmodule

// File: tb/tb_pio_rmw_arbiter.sv
// tb_pio_rmw_arbiter: directed vector bench for pio_rmw_arbiter with a PIO register model.
module tb_pio_rmw_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [7:0]   req_op;
    logic [127:0] req_data;
    logic [3:0]   req_ack;
    logic [1:0]   pio_address;
    logic         pio_chipselect;
    logic         pio_write_n;
    logic [31:0]  pio_writedata;
    logic [31:0]  pio_readdata;
    logic         busy;
    logic [31:0]  pio_reg;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int          idx;
        logic [1:0]  op;
        logic [31:0] data;
        logic [31:0] exp_wd;
        logic [3:0]  exp_ack;
        bit          rmw;
    } vec_t;

    vec_t vecs[9];

    pio_rmw_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_data(req_data), .req_ack(req_ack), .pio_address(pio_address),
        .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .pio_readdata(pio_readdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (pio_chipselect && !pio_write_n && pio_address == 2'd0) pio_reg <= pio_writedata;
    assign pio_readdata = pio_reg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, " cs"}, 64'(pio_chipselect), 64'd0);
        chk({tag, " write_n"}, 64'(pio_write_n), 64'd1);
        chk({tag, " wdata"}, 64'(pio_writedata), 64'd0);
        chk({tag, " ack"}, 64'(req_ack), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int n);
        string tag;
        tag = $sformatf("vec%0d", n);
        @(negedge clk);
        req_valid = 4'b0001 << v.idx;
        req_op = '0;
        req_data = '0;
        req_op[2*v.idx +: 2] = v.op;
        req_data[32*v.idx +: 32] = v.data;
        step();
        chk({tag, " busy"}, 64'(busy), 64'd1);
        // Inputs change after grant; the transaction must use the latched values.
        req_valid = '0;
        req_op = ~req_op;
        req_data = ~req_data;
        if (v.rmw) begin
            chk({tag, " rd cs"}, 64'(pio_chipselect), 64'd1);
            chk({tag, " rd write_n"}, 64'(pio_write_n), 64'd1);
            chk({tag, " rd ack"}, 64'(req_ack), 64'd0);
            step();
        end
        chk({tag, " wr cs"}, 64'(pio_chipselect), 64'd1);
        chk({tag, " wr write_n"}, 64'(pio_write_n), 64'd0);
        chk({tag, " wr addr"}, 64'(pio_address), 64'd0);
        chk({tag, " wr wdata"}, 64'(pio_writedata), 64'(v.exp_wd));
        chk({tag, " wr ack"}, 64'(req_ack), 64'(v.exp_ack));
        step();
        chk({tag, " idle ack"}, 64'(req_ack), 64'd0);
        chk({tag, " idle busy"}, 64'(busy), 64'd0);
        chk({tag, " pio"}, 64'(pio_reg), 64'(v.exp_wd));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_data = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'b0010, 1'b0};
        vecs[1] = '{0, 2'b00, 32'h0000_00F0, 32'h0000_00F0, 4'b0001, 1'b0};
        vecs[2] = '{2, 2'b01, 32'h0000_0F00, 32'h0000_0FF0, 4'b0100, 1'b1};
        vecs[3] = '{3, 2'b00, 32'h0000_00F0, 32'h0000_00F0, 4'b1000, 1'b0};
        vecs[4] = '{1, 2'b10, 32'h0000_0030, 32'h0000_00C0, 4'b0010, 1'b1};
        vecs[5] = '{0, 2'b00, 32'h0000_00F0, 32'h0000_00F0, 4'b0001, 1'b0};
        vecs[6] = '{3, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FF0F, 4'b1000, 1'b1};
        vecs[7] = '{2, 2'b00, 32'h0000_0000, 32'h0000_0000, 4'b0100, 1'b0};
        vecs[8] = '{1, 2'b01, 32'hA5A5_0000, 32'hA5A5_0000, 4'b0010, 1'b1};

        // Reset with random inputs driven
        reset = 1'b1;
        req_valid = 4'($urandom);
        req_op = 8'($urandom);
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = $urandom;
        repeat (3) step();
        idle_outputs("in reset");
        @(negedge clk);
        req_valid = '0;
        reset = 1'b0;
        step();
        idle_outputs("after reset");

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Round-robin: all four hold plain writes from reset
        @(negedge clk);
        reset = 1'b1;
        req_valid = 4'hF;
        req_op = '0;
        for (int i = 0; i < 4; i++) req_data[32*i +: 32] = 32'h100 + i;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            logic [3:0] ea;
            ea = (k % 2 == 1) ? (4'b0001 << (((k - 1) / 2) % 4)) : 4'b0000;
            step();
            chk($sformatf("rr ack k=%0d", k), 64'(req_ack), 64'(ea));
            if (k % 2 == 1)
                chk($sformatf("rr wdata k=%0d", k), 64'(pio_writedata), 64'(32'h100 + ((k - 1) / 2) % 4));
        end
        @(negedge clk);
        req_valid = '0;

        // Atomicity: req0 set and req2 write in the same cycle
        do_reset();
        run_vec('{3, 2'b00, 32'h0000_00F0, 32'h0000_00F0, 4'b1000, 1'b0}, 100);
        @(negedge clk);
        req_valid = 4'b0101;
        req_op = 8'b00_00_00_01;
        req_data = '0;
        req_data[31:0] = 32'h0000_000F;
        req_data[95:64] = 32'h1234_0000;
        step();
        chk("atom E1 rd", 64'({pio_chipselect, pio_write_n, req_ack}), 64'({1'b1, 1'b1, 4'b0000}));
        step();
        chk("atom E2 ack", 64'(req_ack), 64'(4'b0001));
        chk("atom E2 wdata", 64'(pio_writedata), 64'h0000_00FF);
        step();
        chk("atom E3 idle", 64'({pio_chipselect, busy}), 64'd0);
        chk("atom E3 pio", 64'(pio_reg), 64'h0000_00FF);
        step();
        chk("atom E4 ack", 64'(req_ack), 64'(4'b0100));
        chk("atom E4 write_n", 64'(pio_write_n), 64'd0);
        chk("atom E4 wdata", 64'(pio_writedata), 64'h1234_0000);
        @(negedge clk);
        req_valid[2] = 1'b0;
        step();
        chk("atom E5 pio", 64'(pio_reg), 64'h1234_0000);
        step();
        chk("atom E6 rd", 64'({pio_chipselect, pio_write_n, req_ack}), 64'({1'b1, 1'b1, 4'b0000}));
        step();
        chk("atom E7 ack", 64'(req_ack), 64'(4'b0001));
        chk("atom E7 wdata", 64'(pio_writedata), 64'h1234_000F);
        @(negedge clk);
        req_valid = '0;
        step();
        chk("atom final pio", 64'(pio_reg), 64'h1234_000F);

        // Reset during RD of a set (rr_ptr is 1 here)
        @(negedge clk);
        req_valid = 4'b1000;
        req_op = 8'b01_00_00_00;
        req_data = '0;
        req_data[127:96] = 32'h0F00_0000;
        step();
        chk("rst rd cycle", 64'({pio_chipselect, pio_write_n}), 64'({1'b1, 1'b1}));
        reset = 1'b1;
        #1;
        idle_outputs("async rst");
        step();
        idle_outputs("held rst");
        chk("rst pio unchanged", 64'(pio_reg), 64'h1234_000F);
        @(negedge clk);
        req_valid = '0;
        reset = 1'b0;
        step();
        idle_outputs("post rst");
        chk("post rst pio", 64'(pio_reg), 64'h1234_000F);
        // rr_ptr back at 0: req0 must beat req3
        @(negedge clk);
        req_valid = 4'b1001;
        req_op = '0;
        req_data = '0;
        req_data[31:0] = 32'h0000_AAAA;
        req_data[127:96] = 32'h0000_BBBB;
        step();
        chk("ptr0 ack", 64'(req_ack), 64'(4'b0001));
        chk("ptr0 wdata", 64'(pio_writedata), 64'h0000_AAAA);
        @(negedge clk);
        req_valid = '0;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
